// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states
// and the datapath mux/ALU select codes driven by the controller.
package ctrl_pkg;

    localparam int unsigned OP_BITS = 3;

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_SLTI = 3'b001;
    localparam logic [2:0] OP_J    = 3'b010;
    localparam logic [2:0] OP_JAL  = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_ADDI = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [1:0] ALU_FUNCT = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_SLT   = 2'b10;
    localparam logic [1:0] ALU_ADD   = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_R7 = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_CONST2 = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles; expired flags the wait cycle that
// would bring the count up to TIMEOUT. TIMEOUT of 0 never expires.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] count;

    // Wait counter: cleared whenever the controller is not waiting, saturating at LAST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && en && (count == LAST);

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back
// over a shared memory port, stalls on mem_ready, traps on illegal opcodes
// and memory timeouts.
module multicycle_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int          OPCODE_W = 3,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_source,
    output logic                ir_write,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic [1:0]          reg_DST,
    output logic [1:0]          mem_to_reg,
    output logic                ALU_src_A,
    output logic [1:0]          ALU_src_B,
    output logic [1:0]          ALU_op,
    output logic                illegal_op,
    output logic                bus_err,
    output logic                busy
);

    state_t     state;
    logic [2:0] op_q;
    logic       opcode_legal;
    logic       waiting;
    logic       timed_out;

    assign opcode_legal = ((opcode >> OP_BITS) == '0);
    assign waiting      = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!waiting),
        .en     (waiting),
        .expired(timed_out)
    );

    // State sequencing, opcode capture and sticky trap flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            illegal_op <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        state <= S_DECODE;
                    end else if (timed_out) begin
                        state   <= S_TRAP;
                        bus_err <= 1'b1;
                    end
                end
                S_DECODE: begin
                    op_q <= opcode[2:0];
                    if (!opcode_legal) begin
                        state      <= S_TRAP;
                        illegal_op <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_LW, OP_SW:                state <= S_MEM;
                        OP_R, OP_ADDI, OP_SLTI:      state <= S_WB;
                        default:                     state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state <= (op_q == OP_LW) ? S_WB : S_FETCH;
                    end else if (timed_out) begin
                        state   <= S_TRAP;
                        bus_err <= 1'b1;
                    end
                end
                S_WB:    state <= S_FETCH;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath control decode from the current state and captured opcode
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg_DST       = DST_RT;
        mem_to_reg    = M2R_ALUOUT;
        ALU_src_A     = 1'b0;
        ALU_src_B     = SRCB_RT;
        ALU_op        = ALU_FUNCT;
        busy          = (state != S_IDLE) && (state != S_TRAP);
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                ALU_src_B = SRCB_CONST2;
                ALU_op    = ALU_ADD;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    pc_source = PCSRC_ALU;
                end
            end
            S_DECODE: begin
                ALU_src_B = SRCB_IMM_SH;
                ALU_op    = ALU_ADD;
            end
            S_EXEC: begin
                case (op_q)
                    OP_R: begin
                        ALU_src_A = 1'b1;
                    end
                    OP_LW, OP_SW, OP_ADDI: begin
                        ALU_src_A = 1'b1;
                        ALU_src_B = SRCB_IMM;
                        ALU_op    = ALU_ADD;
                    end
                    OP_SLTI: begin
                        ALU_src_A = 1'b1;
                        ALU_src_B = SRCB_IMM;
                        ALU_op    = ALU_SLT;
                    end
                    OP_BEQ: begin
                        ALU_src_A     = 1'b1;
                        ALU_op        = ALU_SUB;
                        pc_write_cond = 1'b1;
                        pc_source     = PCSRC_ALUOUT;
                    end
                    OP_J: begin
                        pc_write  = 1'b1;
                        pc_source = PCSRC_JUMP;
                    end
                    default: begin
                        pc_write   = 1'b1;
                        pc_source  = PCSRC_JUMP;
                        reg_write  = 1'b1;
                        reg_DST    = DST_R7;
                        mem_to_reg = M2R_PC;
                    end
                endcase
            end
            S_MEM: begin
                iord      = 1'b1;
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q == OP_SW);
            end
            S_WB: begin
                reg_write = 1'b1;
                case (op_q)
                    OP_R:    reg_DST    = DST_RD;
                    OP_LW:   mem_to_reg = M2R_MDR;
                    default: begin
                        reg_DST    = DST_RT;
                        mem_to_reg = M2R_ALUOUT;
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed bench for multicycle_ctrl_unit (OPCODE_W=4, TIMEOUT=4).
module tb_multicycle_ctrl_unit;

    // Control vector layout:
    // pc_write, pc_write_cond, pc_source[2], ir_write, iord, mem_read, mem_write,
    // reg_write, reg_DST[2], mem_to_reg[2], ALU_src_A, ALU_src_B[2], ALU_op[2], busy
    localparam logic [18:0] E_IDLE    = 19'b0_0_00_0_0_0_0_0_00_00_0_00_00_0;
    localparam logic [18:0] E_FETCH_W = 19'b0_0_00_0_0_1_0_0_00_00_0_01_11_1;
    localparam logic [18:0] E_FETCH_R = 19'b1_0_00_1_0_1_0_0_00_00_0_01_11_1;
    localparam logic [18:0] E_DECODE  = 19'b0_0_00_0_0_0_0_0_00_00_0_11_11_1;
    localparam logic [18:0] E_EX_R    = 19'b0_0_00_0_0_0_0_0_00_00_1_00_00_1;
    localparam logic [18:0] E_EX_IMM  = 19'b0_0_00_0_0_0_0_0_00_00_1_10_11_1;
    localparam logic [18:0] E_EX_SLTI = 19'b0_0_00_0_0_0_0_0_00_00_1_10_10_1;
    localparam logic [18:0] E_EX_BEQ  = 19'b0_1_01_0_0_0_0_0_00_00_1_00_01_1;
    localparam logic [18:0] E_EX_J    = 19'b1_0_10_0_0_0_0_0_00_00_0_00_00_1;
    localparam logic [18:0] E_EX_JAL  = 19'b1_0_10_0_0_0_0_1_10_10_0_00_00_1;
    localparam logic [18:0] E_MEM_LW  = 19'b0_0_00_0_1_1_0_0_00_00_0_00_00_1;
    localparam logic [18:0] E_MEM_SW  = 19'b0_0_00_0_1_0_1_0_00_00_0_00_00_1;
    localparam logic [18:0] E_WB_R    = 19'b0_0_00_0_0_0_0_1_01_00_0_00_00_1;
    localparam logic [18:0] E_WB_LW   = 19'b0_0_00_0_0_0_0_1_00_01_0_00_00_1;
    localparam logic [18:0] E_WB_IMM  = 19'b0_0_00_0_0_0_0_1_00_00_0_00_00_1;
    localparam logic [18:0] E_TRAP    = 19'b0_0_00_0_0_0_0_0_00_00_0_00_00_0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write;
    logic [1:0] pc_source, reg_DST, mem_to_reg, ALU_src_B, ALU_op;
    logic       ALU_src_A, illegal_op, bus_err, busy;
    logic [18:0] ctl;

    int tests = 0;
    int fails = 0;

    multicycle_ctrl_unit #(
        .OPCODE_W(4),
        .TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .pc_source    (pc_source),
        .ir_write     (ir_write),
        .iord         (iord),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .reg_DST      (reg_DST),
        .mem_to_reg   (mem_to_reg),
        .ALU_src_A    (ALU_src_A),
        .ALU_src_B    (ALU_src_B),
        .ALU_op       (ALU_op),
        .illegal_op   (illegal_op),
        .bus_err      (bus_err),
        .busy         (busy)
    );

    assign ctl = {pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read, mem_write,
                  reg_write, reg_DST, mem_to_reg, ALU_src_A, ALU_src_B, ALU_op, busy};

    always #5 clk = ~clk;

    // Hold reset across one edge, then release shortly after a rising edge.
    task automatic start(input logic [3:0] op);
        rst_n     = 1'b0;
        opcode    = op;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        opcode    = 4'b0000;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (ctl !== E_IDLE) begin
            fails++;
            $display("FAIL reset_ctl: got %b want %b", ctl, E_IDLE);
        end
        tests++;
        if ({illegal_op, bus_err} !== 2'b00) begin
            fails++;
            $display("FAIL reset_flags: got %b want 00", {illegal_op, bus_err});
        end
    endtask

    task automatic test_r_type();
        logic [18:0] e [6];
        e = '{E_IDLE, E_FETCH_R, E_DECODE, E_EX_R, E_WB_R, E_FETCH_R};
        start(4'b0000);
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++;
            if (ctl !== e[i]) begin
                fails++;
                $display("FAIL r_type step %0d: got %b want %b", i, ctl, e[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_lw_wait();
        logic [18:0] e [10];
        logic        m [10];
        e = '{E_IDLE, E_FETCH_R, E_DECODE, E_EX_IMM, E_MEM_LW, E_MEM_LW, E_MEM_LW,
              E_MEM_LW, E_WB_LW, E_FETCH_R};
        m = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        start(4'b0100);
        for (int i = 0; i < 10; i++) begin
            mem_ready = m[i];
            #1;
            tests++;
            if (ctl !== e[i]) begin
                fails++;
                $display("FAIL lw_wait step %0d: got %b want %b", i, ctl, e[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_jal();
        logic [18:0] e [5];
        e = '{E_IDLE, E_FETCH_R, E_DECODE, E_EX_JAL, E_FETCH_R};
        start(4'b0011);
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if (ctl !== e[i]) begin
                fails++;
                $display("FAIL jal step %0d: got %b want %b", i, ctl, e[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // sw, beq, slti, j, addi without reset in between; the opcode input is
    // scrambled after DECODE so later states must follow the captured opcode.
    task automatic test_back_to_back();
        logic [18:0] e  [20];
        logic [3:0]  op [20];
        e  = '{E_IDLE, E_FETCH_R, E_DECODE, E_EX_IMM, E_MEM_SW,
               E_FETCH_R, E_DECODE, E_EX_BEQ,
               E_FETCH_R, E_DECODE, E_EX_SLTI, E_WB_IMM,
               E_FETCH_R, E_DECODE, E_EX_J,
               E_FETCH_R, E_DECODE, E_EX_IMM, E_WB_IMM, E_FETCH_R};
        op = '{4'b0101, 4'b0101, 4'b0101, 4'b0000, 4'b0000,
               4'b0110, 4'b0110, 4'b0010,
               4'b0001, 4'b0001, 4'b0000, 4'b0100,
               4'b0010, 4'b0010, 4'b0011,
               4'b0111, 4'b0111, 4'b0110, 4'b0100, 4'b0111};
        start(4'b0101);
        for (int i = 0; i < 20; i++) begin
            opcode = op[i];
            #1;
            tests++;
            if (ctl !== e[i]) begin
                fails++;
                $display("FAIL back_to_back step %0d: got %b want %b", i, ctl, e[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_illegal_opcode();
        logic [18:0] e [6];
        logic        m [6];
        logic        f [6];
        e = '{E_IDLE, E_FETCH_R, E_DECODE, E_TRAP, E_TRAP, E_TRAP};
        m = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        f = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        start(4'b1000);
        for (int i = 0; i < 6; i++) begin
            mem_ready = m[i];
            #1;
            tests++;
            if (ctl !== e[i] || illegal_op !== f[i]) begin
                fails++;
                $display("FAIL illegal step %0d: got %b/%b want %b/%b",
                         i, ctl, illegal_op, e[i], f[i]);
            end
            @(posedge clk);
            #1;
        end
        tests++;
        if (bus_err !== 1'b0) begin
            fails++;
            $display("FAIL illegal_bus_err: got %b want 0", bus_err);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (illegal_op !== 1'b0) begin
            fails++;
            $display("FAIL illegal_cleared_by_reset: got %b want 0", illegal_op);
        end
    endtask

    task automatic test_timeout();
        logic [18:0] e  [7];
        logic        m  [7];
        logic        f  [7];
        logic [18:0] e2 [7];
        logic        m2 [7];
        logic [18:0] e3 [13];
        logic        m3 [13];
        // four wait cycles in FETCH trap on the edge ending the fourth
        e = '{E_IDLE, E_FETCH_W, E_FETCH_W, E_FETCH_W, E_FETCH_W, E_TRAP, E_TRAP};
        m = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        f = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        start(4'b0000);
        for (int i = 0; i < 7; i++) begin
            mem_ready = m[i];
            #1;
            tests++;
            if (ctl !== e[i] || bus_err !== f[i]) begin
                fails++;
                $display("FAIL timeout_fetch step %0d: got %b/%b want %b/%b",
                         i, ctl, bus_err, e[i], f[i]);
            end
            @(posedge clk);
            #1;
        end
        // ready on what would be the fourth wait cycle completes the fetch
        e2 = '{E_IDLE, E_FETCH_W, E_FETCH_W, E_FETCH_W, E_FETCH_R, E_DECODE, E_EX_R};
        m2 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        start(4'b0000);
        for (int i = 0; i < 7; i++) begin
            mem_ready = m2[i];
            #1;
            tests++;
            if (ctl !== e2[i] || bus_err !== 1'b0) begin
                fails++;
                $display("FAIL timeout_ready_wins step %0d: got %b/%b want %b/0",
                         i, ctl, bus_err, e2[i]);
            end
            @(posedge clk);
            #1;
        end
        // three waits in FETCH then three in MEM: the count restarts per access
        e3 = '{E_IDLE, E_FETCH_W, E_FETCH_W, E_FETCH_W, E_FETCH_R, E_DECODE, E_EX_IMM,
               E_MEM_SW, E_MEM_SW, E_MEM_SW, E_MEM_SW, E_FETCH_R, E_DECODE};
        m3 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        start(4'b0101);
        for (int i = 0; i < 13; i++) begin
            mem_ready = m3[i];
            #1;
            tests++;
            if (ctl !== e3[i] || bus_err !== 1'b0) begin
                fails++;
                $display("FAIL timeout_clear step %0d: got %b/%b want %b/0",
                         i, ctl, bus_err, e3[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [18:0] e [6];
        logic        m [6];
        e = '{E_IDLE, E_FETCH_R, E_DECODE, E_EX_IMM, E_MEM_SW, E_MEM_SW};
        m = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        start(4'b0101);
        for (int i = 0; i < 6; i++) begin
            mem_ready = m[i];
            #1;
            tests++;
            if (ctl !== e[i]) begin
                fails++;
                $display("FAIL reset_mid_mem step %0d: got %b want %b", i, ctl, e[i]);
            end
            if (i < 5) begin
                @(posedge clk);
                #1;
            end
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (mem_write !== 1'b0 || ctl !== E_IDLE) begin
            fails++;
            $display("FAIL reset_mid_mem_async: got %b want %b", ctl, E_IDLE);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        tests++;
        if (ctl !== E_IDLE) begin
            fails++;
            $display("FAIL reset_mid_mem_idle: got %b want %b", ctl, E_IDLE);
        end
        @(posedge clk);
        #1;
        tests++;
        if (ctl !== E_FETCH_R) begin
            fails++;
            $display("FAIL reset_mid_mem_refetch: got %b want %b", ctl, E_FETCH_R);
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_lw_wait();
        test_jal();
        test_back_to_back();
        test_illegal_opcode();
        test_timeout();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_ctrl_unit.md
# multicycle_ctrl_unit

Multicycle control FSM for the 16-bit MIPS core; the successor to the single-cycle control decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states over a shared memory port. It stalls on a `mem_ready` handshake and traps on illegal opcodes or memory timeouts. It sits between the instruction register and the datapath muxes, PC, register file and memory interface.

## Interface
Parameters:
- `OPCODE_W`, default 3: opcode field width. Must be ≥3. Bits above [2:0] must be zero, or the opcode is illegal.
- `TIMEOUT`, default 15: maximum consecutive cycles a memory access may wait for `mem_ready` before trapping. 0 disables the timeout.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  `OPCODE_W`  opcode from the instruction register. Valid from DECODE onward.
- `mem_ready`  in  1  memory accepted or completed the current access this cycle.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load if ALU zero (beq).
- `pc_source`  out  2  PC mux select: 00 = ALU result, 01 = ALU_out register (branch target), 10 = jump target.
- `ir_write`  out  1  IR load.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALU_out.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `reg_write`  out  1  register file write enable.
- `reg_DST`  out  2  register file write address select: 00 = rt, 01 = rd, 10 = r7 (link).
- `mem_to_reg`  out  2  register file write data select: 00 = ALU_out, 01 = MDR, 10 = PC.
- `ALU_src_A`  out  1  ALU A select: 0 = PC, 1 = rs.
- `ALU_src_B`  out  2  ALU B select: 00 = rt, 01 = constant 2, 10 = sign-extended immediate, 11 = shifted immediate.
- `ALU_op`  out  2  ALU operation: 00 = funct, 01 = sub, 10 = slt, 11 = add.
- `illegal_op`  out  1  sticky trap flag for an illegal opcode.
- `bus_err`  out  1  sticky trap flag for a memory timeout.
- `busy`  out  1  high in every state except IDLE and TRAP.

## Operation
Opcodes: 000 R, 001 slti, 010 j, 011 jal, 100 lw, 101 sw, 110 beq, 111 addi.

States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are decoded combinationally from the state and from `op_q`, the opcode registered at DECODE. Any output not listed for a state is 0.

- IDLE: entered on reset; all outputs 0. Goes to FETCH the next cycle.
- FETCH: `mem_read`=1, `iord`=0, `ALU_src_A`=0, `ALU_src_B`=01, `ALU_op`=11. When `mem_ready`=1, also assert `ir_write`=1 and `pc_write`=1 (`pc_source`=00), then go to DECODE.
- DECODE: `ALU_src_A`=0, `ALU_src_B`=11, `ALU_op`=11 (branch target). Register `op_q`. Illegal opcode → TRAP with `illegal_op` set; otherwise → EXEC.
- EXEC, by `op_q`:
  - R: `ALU_src_A`=1, `ALU_src_B`=00, `ALU_op`=00; → WB.
  - lw, sw, addi: `ALU_src_A`=1, `ALU_src_B`=10, `ALU_op`=11; lw and sw → MEM, addi → WB.
  - slti: same as addi but `ALU_op`=10; → WB.
  - beq: `ALU_src_A`=1, `ALU_src_B`=00, `ALU_op`=01, `pc_write_cond`=1, `pc_source`=01; → FETCH.
  - j: `pc_write`=1, `pc_source`=10; → FETCH.
  - jal: as j, plus `reg_write`=1, `reg_DST`=10, `mem_to_reg`=10; → FETCH.
- MEM: `iord`=1 with `mem_read`=1 (lw) or `mem_write`=1 (sw). Strobes hold steady until `mem_ready`. On `mem_ready`, lw → WB and sw → FETCH.
- WB: `reg_write`=1.
  - R: `reg_DST`=01, `mem_to_reg`=00.
  - lw: `reg_DST`=00, `mem_to_reg`=01.
  - addi, slti: `reg_DST`=00, `mem_to_reg`=00.
  - → FETCH.
- TRAP: all strobes and writes 0; trap flags held. Only `rst_n` exits TRAP.
- Wait counter: counts cycles spent in FETCH or MEM with `mem_ready`=0 and clears when the state advances. If `TIMEOUT`≠0 and the count reaches `TIMEOUT` → TRAP with `bus_err` set. `mem_ready` arriving in the same cycle the count reaches `TIMEOUT` wins: the access completes and no trap is raised.
- `mem_ready` is ignored in every state other than FETCH and MEM.

## Timing
- Reset values: state = IDLE; all outputs, `op_q` and the wait counter are 0. Reset asserted mid-instruction aborts it immediately (asynchronous) with no partial writes after the edge.
- Cycles per instruction with zero-wait memory: beq, j, jal = 3; R, addi, slti, sw = 4; lw = 5. Each wait cycle on `mem_ready` adds one.
- The first FETCH occurs in cycle 2 after reset release.
- A trap flag rises on the clock edge that enters TRAP.

## Structure
- Package `ctrl_pkg` holds:
  - opcode constants;
  - the state enum;
  - `ALU_op` codes;
  - encodings for `reg_DST`, `mem_to_reg`, `ALU_src_B` and `pc_source`.
- One sub-module, `mem_wait_timer`: counter of width `$clog2(TIMEOUT+1)` with clear, enable and an `expired` output.

## Test plan
- Release reset with `mem_ready`=1 held, `opcode`=000 → IDLE, FETCH, DECODE, EXEC, WB. WB shows `reg_write`=1, `reg_DST`=01; `busy` stays 1.
- lw with `mem_ready` low for 3 MEM cycles → `mem_read`=1 and `iord`=1 held for 4 cycles, then WB with `mem_to_reg`=01; 8 cycles total.
- jal → EXEC shows `pc_write`=1, `pc_source`=10, `reg_write`=1, `reg_DST`=10, `mem_to_reg`=10; next state FETCH.
- `OPCODE_W`=4 with opcode 1000 → TRAP after DECODE. `illegal_op`=1 and remains set; `busy`=0; further `mem_ready` pulses have no effect.
- `TIMEOUT`=4, `mem_ready`=0 in FETCH → `bus_err`=1 after 4 wait cycles. Repeat with `mem_ready`=1 on the 4th wait cycle → no trap.
- Assert `rst_n` low during MEM of sw → `mem_write` drops to 0 immediately; after release, the sequence restarts from IDLE.
